// File: rtl/fixed_pkg.sv
// Shared constants and state encoding for the sequential fixed-point multiplier.
// Default operand format is Q10.10; the product format is Q10.20.
package fixed_pkg;

   localparam int INTW  = 10;
   localparam int RATW  = 10;
   localparam int W     = INTW + RATW;
   localparam int PRODW = INTW + 2 * RATW;
   localparam int FULLW = 2 * W;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_e;

endpackage

// File: rtl/fixed_mul_seq_if.sv
// Operand/product handshake bundle between the operand source and the multiplier.
// The master modport is the operand source and product sink; the slave modport is the multiplier.
interface fixed_mul_seq_if #(
   parameter int INTW = fixed_pkg::INTW,
   parameter int RATW = fixed_pkg::RATW
);

   logic                       in_valid;
   logic                       in_ready;
   logic [INTW+RATW-1:0]       a;
   logic [INTW+RATW-1:0]       b;
   logic                       out_valid;
   logic                       out_ready;
   logic [INTW+2*RATW-1:0]     prod;
   logic                       ovf;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, prod, ovf
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, prod, ovf
   );

endinterface

// File: rtl/fixed_negate.sv
// Conditional two's-complement negate: out_o = neg_i ? -in_i : in_i.
// Used for operand magnitudes and for restoring the product sign.
module fixed_negate #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] in_i,
   input  logic             neg_i,
   output logic [WIDTH-1:0] out_o
);

   assign out_o = neg_i ? (~in_i + WIDTH'(1)) : in_i;

endmodule

// File: rtl/fixed_mul_seq.sv
// Radix-2 shift-add signed fixed-point multiplier, Q(INTW).(RATW) x Q(INTW).(RATW) -> Q(INTW).(2*RATW).
// Define FIXED_MUL_OVF_EN to build the integer-overflow flag; otherwise ovf stays 0.
module fixed_mul_seq #(
   parameter int INTW = fixed_pkg::INTW,
   parameter int RATW = fixed_pkg::RATW
) (
   input  logic            clk,
   input  logic            rst_n,
   fixed_mul_seq_if.slave  bus
);

   import fixed_pkg::*;

   localparam int OP_W   = INTW + RATW;
   localparam int PROD_W = INTW + 2 * RATW;
   localparam int FULL_W = 2 * OP_W;
   localparam int CNT_W  = $clog2(OP_W + 1);

   state_e              state_q;
   logic [OP_W-1:0]     a_mag;
   logic [OP_W-1:0]     b_mag;
   logic [OP_W-1:0]     mplier_q;
   logic [FULL_W-1:0]   mcand_q;
   logic [FULL_W-1:0]   acc_q;
   logic [FULL_W-1:0]   acc_d;
   logic [FULL_W-1:0]   res;
   logic                sign_q;
   logic [CNT_W-1:0]    count_q;
   logic                in_ready_q;
   logic                out_valid_q;
   logic [PROD_W-1:0]   prod_q;
   logic                ovf_q;
   logic                ovf_d;

   fixed_negate #(.WIDTH(OP_W)) u_abs_a (
      .in_i  (bus.a),
      .neg_i (bus.a[OP_W-1]),
      .out_o (a_mag)
   );

   fixed_negate #(.WIDTH(OP_W)) u_abs_b (
      .in_i  (bus.b),
      .neg_i (bus.b[OP_W-1]),
      .out_o (b_mag)
   );

   // The last partial product is folded in before the sign fix so the result lands on the final BUSY edge.
   assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

   fixed_negate #(.WIDTH(FULL_W)) u_sign_fix (
      .in_i  (acc_d),
      .neg_i (sign_q),
      .out_o (res)
   );

`ifdef FIXED_MUL_OVF_EN
   // Overflow when the dropped integer bits are not a pure sign extension of the kept MSB.
   assign ovf_d = ~((&res[FULL_W-1:PROD_W-1]) | ~(|res[FULL_W-1:PROD_W-1]));
`else
   logic unused_res_hi;
   assign unused_res_hi = ^res[FULL_W-1:PROD_W];
   assign ovf_d         = 1'b0;
`endif

   // NOTE: reset is synchronous, so it lives inside the clocked block; all state uses <= to avoid ordering races.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         prod_q      <= '0;
         ovf_q       <= 1'b0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         sign_q      <= 1'b0;
         count_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  mcand_q    <= FULL_W'(a_mag);
                  mplier_q   <= b_mag;
                  sign_q     <= bus.a[OP_W-1] ^ bus.b[OP_W-1];
                  acc_q      <= '0;
                  count_q    <= CNT_W'(OP_W);
                  in_ready_q <= 1'b0;
                  state_q    <= BUSY;
               end
            end
            BUSY: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               count_q  <= count_q - CNT_W'(1);
               if (count_q == CNT_W'(1)) begin
                  prod_q      <= res[PROD_W-1:0];
                  ovf_q       <= ovf_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.prod      = prod_q;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_fixed_mul_seq.sv
// Directed testbench for fixed_mul_seq in Q10.10; ovf expectations follow FIXED_MUL_OVF_EN.
module tb_fixed_mul_seq;

   localparam int INTW   = 10;
   localparam int RATW   = 10;
   localparam int W      = INTW + RATW;
   localparam int PROD_W = INTW + 2 * RATW;

`ifdef FIXED_MUL_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   typedef struct {
      logic [W-1:0]      a;
      logic [W-1:0]      b;
      logic [PROD_W-1:0] p;
      logic              o;
      string             name;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   fixed_mul_seq_if #(.INTW(INTW), .RATW(RATW)) bus ();

   fixed_mul_seq #(.INTW(INTW), .RATW(RATW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one operand pair from idle, returns the product and the edge count from accept to out_valid.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [PROD_W-1:0] p, output logic o, output int lat);
      bus.a        = a;
      bus.b        = b;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = -1;
      for (int i = 1; i <= W + 10; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) begin
            lat = i;
            break;
         end
      end
      p = bus.prod;
      o = bus.ovf;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.prod !== '0 || bus.ovf !== 1'b0) begin
         n_err++;
         $display("FAIL reset: in_ready=%b out_valid=%b prod=%h ovf=%b, want 1 0 0 0",
                  bus.in_ready, bus.out_valid, bus.prod, bus.ovf);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_products();
      vec_t              v [9];
      logic [PROD_W-1:0] p;
      logic              o;
      int                lat;
      v[0] = '{20'h00400, 20'h00400, 30'h0010_0000, 1'b0, "one_x_one"};
      v[1] = '{20'h00600, 20'hFF800, 30'h3FD0_0000, 1'b0, "1p5_x_m2"};
      v[2] = '{20'h4B000, 20'h01000, 30'h0B00_0000, 1'b1, "300_x_4_ovf"};
      v[3] = '{20'h80000, 20'h80000, 30'h0000_0000, 1'b1, "m512_x_m512_ovf"};
      v[4] = '{20'h00000, 20'hFFFFF, 30'h0000_0000, 1'b0, "zero_x_mlsb"};
      v[5] = '{20'hFFFFF, 20'hFFFFF, 30'h0000_0001, 1'b0, "mlsb_x_mlsb"};
      v[6] = '{20'h7FFFF, 20'h00400, 30'h1FFF_FC00, 1'b0, "max_x_one"};
      v[7] = '{20'h80000, 20'h00400, 30'h2000_0000, 1'b0, "min_x_one"};
      v[8] = '{20'hFFFFF, 20'h00000, 30'h0000_0000, 1'b0, "mlsb_x_zero"};
      for (int k = 0; k < 9; k++) begin
         n_vec++;
         if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s idle: in_ready=%b want 1", v[k].name, bus.in_ready);
         end
         do_op(v[k].a, v[k].b, p, o, lat);
         n_vec++;
         if (lat !== W) begin
            n_err++;
            $display("FAIL %s latency: got %0d edges want %0d", v[k].name, lat, W);
         end
         n_vec++;
         if (p !== v[k].p) begin
            n_err++;
            $display("FAIL %s prod: got %h want %h", v[k].name, p, v[k].p);
         end
         n_vec++;
         if (o !== (v[k].o & OVF_ON)) begin
            n_err++;
            $display("FAIL %s ovf: got %b want %b", v[k].name, o, v[k].o & OVF_ON);
         end
         n_vec++;
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s release: out_valid=%b in_ready=%b want 0 1", v[k].name, bus.out_valid, bus.in_ready);
         end
      end
   endtask

   task automatic test_stall();
      int lat;
      // 5.0 x 2.5 = 12.5 in Q10.20
      bus.a = 20'h01400;
      bus.b = 20'h00A00;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = -1;
      for (int i = 1; i <= W + 10; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) begin
            lat = i;
            break;
         end
      end
      n_vec++;
      if (lat !== W) begin
         n_err++;
         $display("FAIL stall latency: got %0d edges want %0d", lat, W);
      end
      // A new operand pair offered while DONE must be ignored.
      bus.a = 20'h00400;
      bus.b = 20'h00800;
      bus.in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         n_vec++;
         if (bus.out_valid !== 1'b1 || bus.prod !== 30'h00C8_0000 || bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL stall hold %0d: out_valid=%b prod=%h in_ready=%b want 1 00c80000 0",
                     c, bus.out_valid, bus.prod, bus.in_ready);
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      n_vec++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL stall release: out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_reset_mid();
      logic [PROD_W-1:0] p;
      logic              o;
      int                lat;
      bit                stale;
      bus.a = 20'h00400;
      bus.b = 20'h00400;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      n_vec++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.prod !== '0 || bus.ovf !== 1'b0) begin
         n_err++;
         $display("FAIL midreset: in_ready=%b out_valid=%b prod=%h ovf=%b, want 1 0 0 0",
                  bus.in_ready, bus.out_valid, bus.prod, bus.ovf);
      end
      stale = 1'b0;
      for (int i = 0; i < W + 10; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) stale = 1'b1;
      end
      n_vec++;
      if (stale !== 1'b0) begin
         n_err++;
         $display("FAIL midreset stale: out_valid seen=%b want 0", stale);
      end
      // -1.5 x 3.0 = -4.5
      do_op(20'hFFA00, 20'h00C00, p, o, lat);
      n_vec++;
      if (lat !== W || p !== 30'h3FB8_0000 || o !== 1'b0) begin
         n_err++;
         $display("FAIL midreset recover: lat=%0d prod=%h ovf=%b want %0d 3fb80000 0", lat, p, o, W);
      end
   endtask

   task automatic test_back_to_back();
      int                rise1;
      int                acc2;
      int                rise2;
      int                high_cycles;
      logic [PROD_W-1:0] p1;
      logic [PROD_W-1:0] p2;
      bus.a = 20'hFFFFF;
      bus.b = 20'hFFFFF;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.a = 20'h7FFFF;
      bus.b = 20'h00400;
      rise1 = -1;
      acc2  = -1;
      high_cycles = 0;
      p1 = '0;
      for (int i = 1; i <= W + 10; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) begin
            high_cycles++;
            if (rise1 < 0) begin
               rise1 = i;
               p1    = bus.prod;
            end
         end
         if (bus.in_ready) begin
            acc2 = i + 1;
            break;
         end
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n_vec++;
      if (rise1 !== W || p1 !== 30'h0000_0001) begin
         n_err++;
         $display("FAIL b2b first: rise=%0d prod=%h want %0d 00000001", rise1, p1, W);
      end
      n_vec++;
      if (high_cycles !== 1) begin
         n_err++;
         $display("FAIL b2b early out_ready: out_valid cycles=%0d want 1", high_cycles);
      end
      // W busy edges, one handshake edge out of DONE, then one accept edge from IDLE.
      n_vec++;
      if (acc2 !== W + 2) begin
         n_err++;
         $display("FAIL b2b spacing: second accept at edge %0d want %0d", acc2, W + 2);
      end
      rise2 = -1;
      p2 = '0;
      for (int i = 1; i <= W + 10; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) begin
            rise2 = i;
            p2    = bus.prod;
            break;
         end
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      n_vec++;
      if (rise2 !== W || p2 !== 30'h1FFF_FC00) begin
         n_err++;
         $display("FAIL b2b second: rise=%0d prod=%h want %0d 1ffffc00", rise2, p2, W);
      end
      n_vec++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL b2b release: in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a = '0;
      bus.b = '0;
      test_reset();
      test_products();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
